alu_muldiv: RTL and testbench

Parametrised, multi-cycle execute unit for the RV32 core: covers the base integer ALU operations with the same 4-bit encodings, plus the RV32M multiply/divide operations. Operands enter through a valid/ready handshake. Base operations complete in one cycle. Multiply and divide run on iterative shift-add / restoring-divide datapaths. Results are held under a valid/ready output handshake so the core can stall writeback.

---
 rtl/alu_muldiv.sv | 171 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// Multi-cycle RV32 execute unit: single-cycle base ALU ops plus iterative
// shift-add multiply and restoring divide, with valid/ready on both sides.
module alu_muldiv #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW-1:0]   LAST    = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [2:0]       fn_q, fn_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   base_res;
    logic               a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, rem_sh, trial;
    logic [WIDTH:0]     step_acc;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem, fix_res;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        base_res = '0;
        case (op[3:0])
            4'b0000: base_res = a & b;
            4'b0001: base_res = a | b;
            4'b0010: base_res = a + b;
            4'b0110: base_res = a - b;
            4'b0011: base_res = a ^ b;
            4'b0100: base_res = a << b[SHW-1:0];
            4'b0101: base_res = a >> b[SHW-1:0];
            4'b1101: base_res = $signed(a) >>> b[SHW-1:0];
            4'b0111: base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1000: base_res = {{(WIDTH-1){1'b0}}, a < b};
            default: base_res = '0;
        endcase

        a_signed = (op[2:0] == 3'b001) || (op[2:0] == 3'b010) ||
                   (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
        b_signed = (op[2:0] == 3'b001) || (op[2:0] == 3'b100) || (op[2:0] == 3'b110);
        a_neg    = a_signed && a[WIDTH-1];
        b_neg    = b_signed && b[WIDTH-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
    end

    // One iteration of either datapath; the last one feeds the sign fix directly.
    always_comb begin
        sum    = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        rem_sh = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, mcand_q};
        if (fn_q[2]) begin
            step_acc = trial[WIDTH] ? rem_sh : trial;
            step_lo  = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            step_acc = {1'b0, sum[WIDTH:1]};
            step_lo  = {sum[0], lo_q[WIDTH-1:1]};
        end

        prod = {step_acc[WIDTH-1:0], step_lo};
        if (neg_q) prod = -prod;
        quo  = neg_q  ? -step_lo : step_lo;
        rem  = rneg_q ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        if (fn_q[2])                fix_res = fn_q[1] ? rem : quo;
        else if (fn_q[1:0] == 2'b00) fix_res = prod[WIDTH-1:0];
        else                         fix_res = prod[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        fn_d     = fn_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    fn_d    = op[2:0];
                    cnt_d   = '0;
                    acc_d   = '0;
                    lo_d    = a_mag;
                    mcand_d = b_mag;
                    neg_d   = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    state_d = S_ITER;
                    if (!op[4]) begin
                        result_d = base_res;
                        state_d  = S_DONE;
                    end else if (op[2] && b == '0) begin
                        result_d = op[1] ? a : '1;
                        state_d  = S_DONE;
                    end else if (op[2] && !op[0] && a == MIN_NEG && b == '1) begin
                        result_d = op[1] ? '0 : a;
                        state_d  = S_DONE;
                    end
                end
            end
            S_ITER: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            fn_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            fn_q     <= fn_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed corner cases, randomized ops
// against a plain-arithmetic reference model, backpressure and reset abort.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, out_valid, out_ready, zero;
    logic [4:0]   op;
    logic [W-1:0] a, b, result;
    int           checks = 0;
    int           failures = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint     sx, sy, ux, uy;
        logic [63:0] p;
        logic [31:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        r  = '0;
        if (!o[4]) begin
            case (o[3:0])
                4'h0: r = x & y;
                4'h1: r = x | y;
                4'h2: r = x + y;
                4'h6: r = x - y;
                4'h3: r = x ^ y;
                4'h4: r = x << y[4:0];
                4'h5: r = x >> y[4:0];
                4'hD: r = $signed(x) >>> y[4:0];
                4'h7: r = (sx < sy) ? 32'd1 : 32'd0;
                4'h8: r = (x < y) ? 32'd1 : 32'd0;
                default: r = '0;
            endcase
        end else begin
            case (o[2:0])
                3'd0: begin p = 64'(sx * sy); r = p[31:0];  end
                3'd1: begin p = 64'(sx * sy); r = p[63:32]; end
                3'd2: begin p = 64'(sx * uy); r = p[63:32]; end
                3'd3: begin p = 64'(ux * uy); r = p[63:32]; end
                3'd4: r = (y == 0) ? 32'hFFFF_FFFF :
                          (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? x : 32'(sx / sy);
                3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
                3'd6: r = (y == 0) ? x :
                          (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ? 32'd0 : 32'(sx % sy);
                default: r = (y == 0) ? x : x % y;
            endcase
        end
        return r;
    endfunction

    function automatic int exp_latency(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[4]) return 1;
        if (o[2] && y == 0) return 1;
        if (o[2] && !o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return W + 1;
    endfunction

    // Issue one op, scramble the inputs after accept, wait for the result, then take it.
    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output logic z, output int lat);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready got=%b exp=1", in_ready);
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        res = result;
        z   = zero;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_handshake out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_state in_ready=%b out_valid=%b result=%h zero=%b exp 1/0/0/1",
                     in_ready, out_valid, result, zero);
        end
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  o;
        logic [31:0] x, y, exp;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t        v[16];
        logic [31:0] res;
        logic        z;
        int          lat;
        v[0]  = '{5'h02, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1};
        v[1]  = '{5'h06, 32'h5,         32'h5,         32'h0,         1};
        v[2]  = '{5'h0D, 32'h8000_0000, 32'h24,        32'hF800_0000, 1};
        v[3]  = '{5'h08, 32'h1,         32'hFFFF_FFFF, 32'h1,         1};
        v[4]  = '{5'h07, 32'h1,         32'hFFFF_FFFF, 32'h0,         1};
        v[5]  = '{5'h11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         33};
        v[6]  = '{5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        v[7]  = '{5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        v[8]  = '{5'h14, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33};
        v[9]  = '{5'h16, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33};
        v[10] = '{5'h15, 32'h7,         32'h0,         32'hFFFF_FFFF, 1};
        v[11] = '{5'h17, 32'h7,         32'h0,         32'h7,         1};
        v[12] = '{5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        v[13] = '{5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
        v[14] = '{5'h18, 32'd123,       32'd456,       32'd56088,     33};
        v[15] = '{5'h09, 32'h1234,      32'h5678,      32'h0,         1};
        for (int i = 0; i < 16; i++) begin
            do_op(v[i].o, v[i].x, v[i].y, res, z, lat);
            checks++;
            if (res !== v[i].exp) begin
                failures++;
                $display("FAIL directed_result[%0d] op=%h got=%h exp=%h", i, v[i].o, res, v[i].exp);
            end
            checks++;
            if (z !== (v[i].exp == 0)) begin
                failures++;
                $display("FAIL directed_zero[%0d] got=%b exp=%b", i, z, v[i].exp == 0);
            end
            checks++;
            if (lat != v[i].lat) begin
                failures++;
                $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, v[i].lat);
            end
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials[6];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3};
        case ($urandom_range(0, 3))
            0:       return specials[$urandom_range(0, 5)];
            1:       return 32'($urandom_range(0, 40)) - 32'd20;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [4:0]  o;
        logic [31:0] x, y, exp, res;
        logic        z;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            o = 5'($urandom_range(0, 31));
            x = pick_operand();
            y = pick_operand();
            exp = model(o, x, y);
            do_op(o, x, y, res, z, lat);
            checks++;
            if (res !== exp || z !== (exp == 0)) begin
                failures++;
                $display("FAIL random_result op=%h a=%h b=%h got=%h/%b exp=%h/%b", o, x, y, res, z, exp, exp == 0);
            end
            checks++;
            if (lat != exp_latency(o, x, y)) begin
                failures++;
                $display("FAIL random_latency op=%h got=%0d exp=%0d", o, lat, exp_latency(o, x, y));
            end
        end
    endtask

    task automatic test_backpressure();
        int waited = 0;
        @(negedge clk);
        op = 5'h15; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (out_valid !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd14 || zero !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold[%0d] out_valid=%b in_ready=%b result=%h exp 1/0/0000000e",
                         i, out_valid, in_ready, result);
            end
            op = 5'h02; a = 32'(i); b = 32'd1; in_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd14) begin
            failures++;
            $display("FAIL backpressure_ignore out_valid=%b result=%h exp 1/0000000e", out_valid, result);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
        op = 5'h02; a = 32'd9; b = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd10) begin
            failures++;
            $display("FAIL back_to_back out_valid=%b result=%h exp 1/0000000a", out_valid, result);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] res;
        logic        z;
        int          lat;
        @(negedge clk);
        op = 5'h10; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_abort out_valid=%b in_ready=%b result=%h zero=%b exp 0/1/0/1",
                     out_valid, in_ready, result, zero);
        end
        repeat (W + 4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_abort_discard out_valid=%b exp 0", out_valid);
        end
        do_op(5'h02, 32'd2, 32'd3, res, z, lat);
        checks++;
        if (res !== 32'd5 || lat != 1) begin
            failures++;
            $display("FAIL after_abort_add got=%h lat=%0d exp=00000005 lat=1", res, lat);
        end
        @(negedge clk);
        rst = 1'b1; op = 5'h02; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_wins out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
